// File: rtl/gpr_bank_param.sv
// Parametrised register bank on a shared tri-state bus, with masked asserters, counting registers and sticky contention.
// Bus drive is combinational; register and contention updates take effect on the rising clkBar edge.
module gpr_bank_param #(
    parameter int                WIDTH       = 8,
    parameter int                NREGS       = 4,
    parameter logic [NREGS-1:0]  ASSERT_MASK = 4'b0101,
    parameter logic [NREGS-1:0]  COUNT_MASK  = 4'b0100
) (
    input  logic                    clkBar,
    input  logic                    resetBar,
    input  logic [NREGS-1:0]        load,
    input  logic [NREGS-1:0]        assertBar,
    input  logic [NREGS-1:0]        inc,
    input  logic [NREGS-1:0]        dec,
    input  logic                    clearContention,
    inout  wire  [WIDTH-1:0]        dbus,
    output logic [NREGS*WIDTH-1:0]  regs,
    output logic [NREGS-1:0]        zero,
    output logic                    contention,
    output logic                    busDriven
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NREGS-1:0] ONE_N = {{(NREGS-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] eff;
    logic [WIDTH-1:0] drv_dat;
    logic             drv_any;
    logic             multi;

    assign eff = ~assertBar & ASSERT_MASK;
    // Clearing the lowest set bit leaves something only if two or more asserters are active.
    assign multi = |(eff & (eff - ONE_N));

    // Scan high to low so the lowest-index asserter is the last (winning) assignment.
    always_comb begin
        drv_any = 1'b0;
        drv_dat = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                drv_any = 1'b1;
                drv_dat = regs_q[i];
            end
        end
    end

    assign busDriven = drv_any & resetBar;
    assign dbus      = busDriven ? drv_dat : {WIDTH{1'bz}};

    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (load[i]) begin
                    regs_q[i] <= dbus;
                end else if (COUNT_MASK[i] && inc[i] && !dec[i]) begin
                    regs_q[i] <= regs_q[i] + ONE_W;
                end else if (COUNT_MASK[i] && dec[i] && !inc[i]) begin
                    regs_q[i] <= regs_q[i] - ONE_W;
                end
            end
        end
    end

    // A fresh contention takes precedence over a simultaneous clear.
    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            contention <= 1'b0;
        end else if (multi) begin
            contention <= 1'b1;
        end else if (clearContention) begin
            contention <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_out
        assign regs[g*WIDTH +: WIDTH] = regs_q[g];
        assign zero[g]                = (regs_q[g] == '0);
    end

endmodule
